uart_rx_core: RTL and testbench

- User-project UART receiver sitting downstream of the serial line on mprj_io[5].
- That line is driven by the off-chip or testbench UART transmitter.
- Recovers 8N1 frames from the asynchronous rx pin and stores received bytes in a small FIFO.
- Presents bytes to the Wishbone-side register logic over a valid/ready handshake, with sticky frame-error and overrun flags.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_core.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned MIN_DIV   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Short divisors leave no room to find the middle of a bit, so clamp them.
  function automatic int unsigned eff_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO with occupancy output.
module uart_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);
  localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    valid_o  = (level_q != '0);
    full_o   = (level_q == FullLvl);
    do_pop   = pop_i & valid_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LvlOne;
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlOne;
    end
    rdata_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    level_o  = level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and byte FIFO
// with sticky frame-error and overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  input  logic [DIV_W-1:0]            baud_div_i,
  output logic [DATA_BITS-1:0]        rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  input  logic                        clear_err_i,
  output logic                        busy_o
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);
  localparam logic [IdxW-1:0]  IdxOne  = IdxW'(1);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, frame_set, pop, drop, fifo_full;

  // rx_i is asynchronous; only rx_s_q is used past this point.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;

    if (!rx_en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            div_d   = DIV_W'(eff_div(32'(baud_div_i)));
            cnt_d   = (div_d >> 1) - DivOne;
            state_d = StStart;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              cnt_d   = div_q - DivOne;
              idx_d   = '0;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q - DivOne;
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            cnt_d   = div_q - DivOne;
            idx_d   = idx_q + IdxOne;
            if (idx_q == LastIdx) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q - DivOne;
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              push    = 1'b1;
              state_d = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StBreak;
            end
          end else begin
            cnt_d = cnt_q - DivOne;
          end
        end
        StBreak: begin
          // Wait out a held-low line instead of decoding it as 0x00 frames.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pop         = rx_valid_o & rx_ready_i;
    drop        = push & fifo_full & ~pop;
    // A set condition beats a simultaneous clear.
    frame_err_d = frame_set | (frame_err_q & ~clear_err_i);
    overrun_d   = drop | (overrun_q & ~clear_err_i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= DIV_W'(MIN_DIV);
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data_o),
    .valid_o (rx_valid_o),
    .full_o  (fifo_full),
    .level_o (rx_level_o)
  );

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: queue-based FIFO/flag model checked every
// cycle, plus hand-computed literal checks per scenario.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned FD = 4;
  localparam int unsigned D  = 16;

  logic        clk = 1'b0;
  logic        rst, rx, rx_en, ready, clear;
  logic [15:0] baud;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun, busy;
  logic [2:0]  rx_level;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mq[$];
  bit          m_ferr = 1'b0;
  bit          m_ovr  = 1'b0;
  bit          chk_on = 1'b0;
  logic [7:0]  exp_d;
  bit          exp_v;
  logic [7:0]  t2 [4] = '{8'h0F, 8'hA5, 8'hFF, 8'h00};
  logic [7:0]  t4 [4] = '{8'hA5, 8'hFF, 8'h00, 8'h77};

  always #5 clk = ~clk;

  uart_rx_core #(
    .FIFO_DEPTH (FD),
    .DIV_W      (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_i        (rx),
    .rx_en_i     (rx_en),
    .baud_div_i  (baud),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (ready),
    .rx_level_o  (rx_level),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .clear_err_i (clear),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: the model applies what the bench presented at this edge.
  task automatic tick(input bit push, input logic [7:0] b, input bit ferr);
    bit pop_now;
    bit drop;
    @(posedge clk);
    pop_now = ready && (mq.size() != 0);
    if (rst) begin
      mq.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      drop = push && (mq.size() == FD) && !pop_now;
      if (push && !drop) mq.push_back(b);
      if (pop_now) void'(mq.pop_front());
      m_ferr = ferr || (m_ferr && !clear);
      m_ovr  = drop || (m_ovr && !clear);
    end
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  // Stop sample lies d*9.5 cycles after the synchronized edge; with the
  // 2-flop sync that edge is iteration 2 + d/2 + 9d after driving the start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_at_push,
                            input int d);
    logic [9:0] fr;
    int push_c;
    int n;
    fr     = {stop, b, 1'b0};
    push_c = 2 + d / 2 + 9 * d;
    for (int c = 0; c < 10 * d + 4; c++) begin
      n  = c / d;
      rx = (n <= 9) ? fr[n] : stop;
      if (pop_at_push) ready = (c == push_c);
      tick((c == push_c) && stop, b, (c == push_c) && !stop);
    end
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      exp_v = (mq.size() != 0);
      exp_d = exp_v ? mq[0] : 8'h00;
      n_cmp++;
      if (rx_valid !== exp_v || rx_data !== exp_d || rx_level !== 3'(mq.size()) ||
          frame_err !== m_ferr || overrun !== m_ovr) begin
        n_bad++;
        $display("FAIL model t=%0t: got v=%b d=%h lvl=%0d fe=%b ov=%b, expected v=%b d=%h lvl=%0d fe=%b ov=%b",
                 $time, rx_valid, rx_data, rx_level, frame_err, overrun,
                 exp_v, exp_d, mq.size(), m_ferr, m_ovr);
      end
    end
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rx_en = 1'b1; ready = 1'b0; clear = 1'b0; baud = 16'd16;
    tick(1'b0, 8'h00, 1'b0);
    chk_on = 1'b1;
    wait_ticks(2);
    rst = 1'b0;
    wait_ticks(2);
    check("reset valid", 32'(rx_valid), 32'd0);
    check("reset data", 32'(rx_data), 32'h00);
    check("reset level", 32'(rx_level), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset flags", 32'({frame_err, overrun}), 32'd0);

    // Basic byte
    send_frame(8'h3D, 1'b1, 1'b0, D);
    check("t1 valid", 32'(rx_valid), 32'd1);
    check("t1 data", 32'(rx_data), 32'h3D);
    check("t1 level", 32'(rx_level), 32'd1);
    check("t1 frame_err", 32'(frame_err), 32'd0);
    pop_one();
    check("t1 empty after pop", 32'(rx_valid), 32'd0);

    // Multi-byte fill and in-order drain
    for (int i = 0; i < 4; i++) begin
      send_frame(t2[i], 1'b1, 1'b0, D);
      check("t2 level", 32'(rx_level), 32'(i + 1));
    end
    wait_ticks(20);
    check("t2 level holds", 32'(rx_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2 pop data", 32'(rx_data), 32'(t2[i]));
      pop_one();
    end
    check("t2 empty", 32'(rx_valid), 32'd0);

    // Overrun
    for (int i = 0; i < 4; i++) send_frame(t2[i], 1'b1, 1'b0, D);
    send_frame(8'h55, 1'b1, 1'b0, D);
    check("t3 overrun", 32'(overrun), 32'd1);
    check("t3 level", 32'(rx_level), 32'd4);
    check("t3 head", 32'(rx_data), 32'h0F);
    clear = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    clear = 1'b0;
    check("t3 cleared", 32'(overrun), 32'd0);

    // Push and pop on the same edge while full
    send_frame(8'h77, 1'b1, 1'b1, D);
    check("t4 no overrun", 32'(overrun), 32'd0);
    check("t4 level", 32'(rx_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4 pop data", 32'(rx_data), 32'(t4[i]));
      pop_one();
    end
    check("t4 empty", 32'(rx_level), 32'd0);

    // Framing error then held-low break
    send_frame(8'h12, 1'b0, 1'b0, D);
    wait_ticks(3 * D);
    check("t5 frame_err", 32'(frame_err), 32'd1);
    check("t5 nothing pushed", 32'(rx_level), 32'd0);
    check("t5 busy in break", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_ticks(4);
    check("t5 idle after break", 32'(busy), 32'd0);
    send_frame(8'h34, 1'b1, 1'b0, D);
    check("t5 next data", 32'(rx_data), 32'h34);
    check("t5 next level", 32'(rx_level), 32'd1);

    // Glitch shorter than half a bit
    rx = 1'b0;
    wait_ticks(4);
    check("t6 glitch busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_ticks(20);
    check("t6 glitch idle", 32'(busy), 32'd0);
    check("t6 glitch level", 32'(rx_level), 32'd1);

    // Enable dropped mid-frame
    rx = 1'b0;
    wait_ticks(30);
    check("t6 busy mid-frame", 32'(busy), 32'd1);
    rx_en = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    check("t6 disable idle", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_ticks(4);
    rx_en = 1'b1;
    wait_ticks(4);
    check("t6 disable keeps fifo", 32'(rx_level), 32'd1);

    // Reset mid-frame with two bytes queued
    send_frame(8'h56, 1'b1, 1'b0, D);
    check("t6 two queued", 32'(rx_level), 32'd2);
    rx = 1'b0;
    wait_ticks(40);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    check("t6 rst valid", 32'(rx_valid), 32'd0);
    check("t6 rst data", 32'(rx_data), 32'h00);
    check("t6 rst level", 32'(rx_level), 32'd0);
    check("t6 rst flags", 32'({frame_err, overrun}), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_ticks(5);

    // Divisor below the minimum runs at D=4
    baud = 16'd2;
    send_frame(8'hC3, 1'b1, 1'b0, 4);
    check("clamp data", 32'(rx_data), 32'hC3);
    check("clamp level", 32'(rx_level), 32'd1);
    wait_ticks(4);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
